// File: rtl/seg_pkg.sv
// Shared definitions for the 2-digit seven-segment display driver.
//   conv_state_t : converter FSM states (IDLE, SHIFT, COMMIT)
//   SEG_0..SEG_9 : active-low glyphs, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK    : all segments off
//   seg_glyph()  : BCD digit -> glyph; any non-decimal code blanks
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } conv_state_t;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
      case (digit)
         4'd0:    seg_glyph = SEG_0;
         4'd1:    seg_glyph = SEG_1;
         4'd2:    seg_glyph = SEG_2;
         4'd3:    seg_glyph = SEG_3;
         4'd4:    seg_glyph = SEG_4;
         4'd5:    seg_glyph = SEG_5;
         4'd6:    seg_glyph = SEG_6;
         4'd7:    seg_glyph = SEG_7;
         4'd8:    seg_glyph = SEG_8;
         4'd9:    seg_glyph = SEG_9;
         default: seg_glyph = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
// One input bit is consumed per SHIFT cycle; a full conversion takes
// IN_W SHIFT cycles followed by one COMMIT cycle.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : capture bin and begin a conversion (ignored while busy)
//   bin        : binary value to convert
//   busy       : registered, high from the cycle after start through COMMIT
//   done       : high during COMMIT; tens/ones are final in that cycle
//   tens, ones : BCD scratch nibbles
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int IN_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [IN_W-1:0] bin,
   output logic            busy,
   output logic            done,
   output logic [3:0]      tens,
   output logic [3:0]      ones
);

   localparam logic [2:0] LAST_BIT = 3'(IN_W - 1);

   conv_state_t     state;
   logic [IN_W-1:0] sh_reg;
   logic [7:0]      scratch;
   logic [7:0]      scratch_adj;
   logic [2:0]      bit_cnt;

   // Any nibble >= 5 would exceed 9 after doubling, so pre-correct by 3.
   function automatic logic [7:0] dabble_adj(input logic [7:0] s);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = s[7:4];
      lo = s[3:0];
      if (hi >= 4'd5) hi = hi + 4'd3;
      if (lo >= 4'd5) lo = lo + 4'd3;
      return {hi, lo};
   endfunction

   assign scratch_adj = dabble_adj(scratch);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         bit_cnt <= 3'd0;
         sh_reg  <= '0;
         scratch <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sh_reg  <= bin;
                  scratch <= 8'd0;
                  bit_cnt <= 3'd0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= {scratch_adj[6:0], sh_reg[IN_W-1]};
               sh_reg  <= {sh_reg[IN_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == LAST_BIT) state <= COMMIT;
            end
            COMMIT: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign done = (state == COMMIT);
   assign tens = scratch[7:4];
   assign ones = scratch[3:0];

endmodule

// File: rtl/seg_disp_drv.sv
// Two-digit, common-anode, time-multiplexed seven-segment driver.
// New binary counts are converted to BCD by bin2bcd_seq; the displayed
// digits only change when a conversion commits.
// Optional macro SEG_LEAD_ZERO_BLANK_EN: blank the tens slot when the
// tens digit is 0 (anode still scanned so brightness stays uniform).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid, in_data  : one-cycle qualified 6-bit binary count
//   busy               : conversion in progress, in_valid ignored
//   bcd_tens, bcd_ones : registered digits currently displayed
//   seg                : {g,f,e,d,c,b,a}, active-low
//   dig_an             : anodes, active-low; bit0 = ones, bit1 = tens
module seg_disp_drv
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int IN_W     = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [IN_W-1:0] in_data,
   output logic            busy,
   output logic [3:0]      bcd_tens,
   output logic [3:0]      bcd_ones,
   output logic [6:0]      seg,
   output logic [1:0]      dig_an
);

   localparam int               CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic             conv_done;
   logic [3:0]       conv_tens;
   logic [3:0]       conv_ones;
   logic [CNT_W-1:0] scan_cnt;
   logic             scan_idx;
   logic             idx_d;
   logic [3:0]       tens_d;
   logic [3:0]       ones_d;
   logic [6:0]       glyph_d;

   bin2bcd_seq #(
      .IN_W (IN_W)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (in_valid),
      .bin   (in_data),
      .busy  (busy),
      .done  (conv_done),
      .tens  (conv_tens),
      .ones  (conv_ones)
   );

   // Glyph is built from next-cycle digit/index values so seg, dig_an and
   // the BCD registers all move on the same edge.
   always_comb begin
      tens_d = bcd_tens;
      ones_d = bcd_ones;
      if (conv_done) begin
         tens_d = conv_tens;
         ones_d = conv_ones;
      end
      idx_d   = (scan_cnt == CNT_LAST) ? ~scan_idx : scan_idx;
      glyph_d = seg_glyph(idx_d ? tens_d : ones_d);
`ifdef SEG_LEAD_ZERO_BLANK_EN
      if (idx_d && (tens_d == 4'd0)) glyph_d = SEG_BLANK;
`else
      glyph_d = glyph_d;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         scan_idx <= 1'b0;
         bcd_tens <= 4'd0;
         bcd_ones <= 4'd0;
         seg      <= SEG_0;
         dig_an   <= 2'b10;
      end else begin
         scan_cnt <= (scan_cnt == CNT_LAST) ? '0 : scan_cnt + 1'b1;
         scan_idx <= idx_d;
         bcd_tens <= tens_d;
         bcd_ones <= ones_d;
         seg      <= glyph_d;
         dig_an   <= idx_d ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: tb/tb_seg_disp_drv.sv
module tb_seg_disp_drv;

   localparam int SCAN_DIV = 4;
`ifdef SEG_LEAD_ZERO_BLANK_EN
   localparam logic [6:0] TENS_ZERO_SEG = 7'h7F;
`else
   localparam logic [6:0] TENS_ZERO_SEG = 7'h40;
`endif

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [5:0] in_data;
   logic       busy;
   logic [3:0] bcd_tens;
   logic [3:0] bcd_ones;
   logic [6:0] seg;
   logic [1:0] dig_an;

   int checks = 0;
   int errors = 0;

   seg_disp_drv #(
      .SCAN_DIV (SCAN_DIV),
      .IN_W     (6)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .busy     (busy),
      .bcd_tens (bcd_tens),
      .bcd_ones (bcd_ones),
      .seg      (seg),
      .dig_an   (dig_an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a value for one cycle; returns just after the sampling edge (cycle 0).
   task automatic pulse(input logic [5:0] val);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = val;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Full conversion with busy/latency checks; ends sampling cycle 8.
   task automatic convert(input string tag, input logic [5:0] val,
                          input logic [3:0] exp_t, input logic [3:0] exp_o);
      pulse(val);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         chk({tag, "_busy"}, busy, 1'b1);
      end
      @(negedge clk);
      chk({tag, "_busy_c8"}, busy, 1'b0);
      chk({tag, "_tens"}, bcd_tens, exp_t);
      chk({tag, "_ones"}, bcd_ones, exp_o);
   endtask

   task automatic wait_slot(input logic [1:0] an, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3 * SCAN_DIV; i++) begin
         @(negedge clk);
         if (dig_an == an) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_slots(input string tag, input logic [6:0] tens_seg, input logic [6:0] ones_seg);
      bit ok;
      wait_slot(2'b01, ok);
      chk({tag, "_tens_slot_seen"}, ok, 1'b1);
      if (ok) chk({tag, "_tens_seg"}, seg, tens_seg);
      wait_slot(2'b10, ok);
      chk({tag, "_ones_slot_seen"}, ok, 1'b1);
      if (ok) chk({tag, "_ones_seg"}, seg, ones_seg);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 6'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state and idle scan: 4 cycles tens-off/ones-on, then swapped
      chk("rst_busy", busy, 1'b0);
      chk("rst_tens", bcd_tens, 4'd0);
      chk("rst_ones", bcd_ones, 4'd0);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         chk($sformatf("idle_an_%0d", i), dig_an, (i < 4) ? 2'b10 : 2'b01);
         chk($sformatf("idle_seg_%0d", i), seg, (i < 4) ? 7'h40 : TENS_ZERO_SEG);
      end

      convert("c59", 6'd59, 4'd5, 4'd9);
      check_slots("c59", 7'h12, 7'h10);

      convert("c63", 6'd63, 4'd6, 4'd3);
      check_slots("c63", 7'h02, 7'h30);

      convert("c0", 6'd0, 4'd0, 4'd0);
      check_slots("c0", TENS_ZERO_SEG, 7'h40);

      // 17 offered while 42 is converting must be dropped
      pulse(6'd42);
      repeat (2) @(negedge clk);
      @(negedge clk);
      chk("drop_busy_c3", busy, 1'b1);
      in_valid = 1'b1;
      in_data  = 6'd17;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("drop_busy_c8", busy, 1'b0);
      chk("drop_tens", bcd_tens, 4'd4);
      chk("drop_ones", bcd_ones, 4'd2);
      repeat (10) @(negedge clk);
      chk("drop_busy_late", busy, 1'b0);
      chk("drop_tens_late", bcd_tens, 4'd4);
      chk("drop_ones_late", bcd_ones, 4'd2);
      check_slots("c42", 7'h19, 7'h24);

      // Reset in cycle 4 of converting 38
      pulse(6'd38);
      repeat (3) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_tens", bcd_tens, 4'd0);
      chk("midrst_ones", bcd_ones, 4'd0);
      repeat (8) @(negedge clk);
      chk("midrst_busy_late", busy, 1'b0);
      chk("midrst_tens_late", bcd_tens, 4'd0);
      chk("midrst_ones_late", bcd_ones, 4'd0);
      convert("c38", 6'd38, 4'd3, 4'd8);
      check_slots("c38", 7'h30, 7'h00);

      // rst together with in_valid: nothing captured
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 6'd25;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rstvld_busy", busy, 1'b0);
      repeat (9) @(negedge clk);
      chk("rstvld_busy_late", busy, 1'b0);
      chk("rstvld_tens", bcd_tens, 4'd0);
      chk("rstvld_ones", bcd_ones, 4'd0);

      // Leading-zero handling of the tens slot
      convert("c7", 6'd7, 4'd0, 4'd7);
      check_slots("c7", TENS_ZERO_SEG, 7'h78);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_disp_drv.md
Name: seg_disp_drv

Overview:
- Downstream consumer of the 6-bit seconds/minutes counter (cnt6 / top_cnt output).
- Converts each new 6-bit binary count (0–63) to two BCD digits with a sequential shift-add-3 (double-dabble) converter.
- Drives a 2-digit, common-anode, time-multiplexed 7-segment display on the board.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot (1 kHz digit rate at 50 MHz); legal range ≥ 2.
- IN_W, 6, binary input width; fixed at 6 for this revision.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, reset; one clock; reset is synchronous and active-high.
- in_valid, input, 1, qualifies in_data for one cycle.
- in_data, input, 6, binary count to display.
- busy, output, 1, conversion in progress; in_valid is ignored while high.
- bcd_tens, output, 4, registered tens digit currently displayed.
- bcd_ones, output, 4, registered ones digit currently displayed.
- seg, output, 7, {g,f,e,d,c,b,a}, active-low.
- dig_an, output, 2, digit anodes, active-low; bit0 = ones, bit1 = tens.

Behaviour:
- Reset values:
  - busy = 0; bcd_tens = bcd_ones = 0.
  - Scan counter = 0; digit index = 0, so dig_an = 2'b10.
  - seg = 7'b1000000 (glyph "0").
- Converter FSM has three states: IDLE, SHIFT, COMMIT.
  - IDLE → SHIFT when in_valid = 1. in_data is captured into the shift register and the BCD scratch is cleared.
  - SHIFT lasts exactly 6 cycles. Each cycle: add 3 to any scratch nibble ≥ 5, then shift left by 1, bringing in the binary MSB.
  - COMMIT lasts 1 cycle: scratch is copied into bcd_tens/bcd_ones, then the FSM returns to IDLE.
- Latency and busy: define the cycle in which in_valid is sampled as cycle 0.
  - busy is high in cycles 1–7.
  - The new bcd_tens/bcd_ones are visible from cycle 8.
  - in_valid may be asserted again in cycle 8.
- in_valid while busy = 1 is dropped; there is no queueing and no error flag.
- Range: all inputs 0–63 are converted exactly, so the tens digit is at most 6. No clamping.
- Scan:
  - The counter runs 0..SCAN_DIV-1 continuously and is independent of the FSM.
  - On wrap, the digit index toggles.
  - Index 0 drives dig_an = 2'b10 with seg = glyph(bcd_ones); index 1 drives dig_an = 2'b01 with seg = glyph(bcd_tens).
  - seg and dig_an are registered and change on the same edge, so no ghosting cycle occurs.
- Glyphs, indexed 0–9 (a = bit0):
  - 0 = 40h, 1 = 79h, 2 = 24h, 3 = 30h, 4 = 19h
  - 5 = 12h, 6 = 02h, 7 = 78h, 8 = 00h, 9 = 10h
  - Any other code = 7Fh (blank).
- Display regs change only in COMMIT, so the display never shows a partial conversion.
- Reset mid-conversion: FSM goes to IDLE, busy = 0, and displayed digits return to 0 on the next cycle. Captured data is discarded.
- Simultaneous rst and in_valid: rst wins and the input is not captured.

Optional Feature:
- Macro: SEG_LEAD_ZERO_BLANK_EN.
- Defined: when bcd_tens = 0, the tens slot drives seg = 7Fh. dig_an still scans normally, keeping brightness constant.
- Undefined: the tens slot always shows its glyph, including "0".
- bcd_tens/bcd_ones outputs are unaffected in both cases.

Decomposition:
- Package seg_pkg holds:
  - the state enum (IDLE/SHIFT/COMMIT);
  - the 7-bit glyph constants SEG_0..SEG_9 and SEG_BLANK;
  - a seg_glyph(4-bit) function.
- One sub-module, bin2bcd_seq, contains the FSM and shift register. It has ports clk, rst, start, bin, busy, done, tens, ones.
- The top level (seg_disp_drv) holds the display regs, scan counter and glyph mux.

Test Plan:
- Reset then idle → dig_an alternates 10/01 every SCAN_DIV cycles; seg = 40h in both slots.
- SCAN_DIV=4, in_data=59 pulsed at cycle 0:
  - busy = 1 for cycles 1–7;
  - from cycle 8, bcd_tens=5 and bcd_ones=9;
  - seg = 12h in the tens slot and 10h in the ones slot.
- in_data=63 → tens=6, ones=3 (seg 02h/30h). Then in_data=0 → tens=0, ones=0.
- in_data=42 accepted, then in_data=17 pulsed at cycle 3 (while busy) → the display shows 4/2 and 17 never appears.
- rst asserted at cycle 4 of a conversion of 38 → busy = 0 next cycle and digits read 0/0. A fresh 38 afterwards yields 3/8.
- With SEG_LEAD_ZERO_BLANK_EN, in_data=7 → tens slot seg = 7Fh, ones slot = 78h. Without the macro, the tens slot shows 40h.
